data_mem_responder: RTL

//  Word-addressed data memory that services load/store requests from the data-movement execute unit.

---
 rtl/data_mem_responder.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/data_mem_responder.sv
// data_mem_responder: word-addressed data memory behind a valid/ready request port.
// It accepts one load or store at a time. Each request gets a single-cycle response pulse
// that flags misaligned or out-of-range accesses.
//
// Handshake: a request transfers at a rising edge where req_valid && req_ready.
// req_ready is high only in IDLE and is never high while reset is asserted.
// At any other time the request inputs are ignored, and the initiator may change them freely.
// The response is the single cycle in which rsp_valid is high. rsp_rdata and rsp_err are meaningful only in that cycle.
// A store responds in the cycle after its acceptance edge.
// A load responds in the cycle ending at the READ_LATENCY-th rising edge after acceptance.
//
// Optional feature: define DATA_MEM_RESPONDER_MMIO_OUT_EN to map an output register at MMIO_ADDR.
// Without it, io_out/io_out_valid are tied low and MMIO_ADDR is an ordinary out-of-range address.
module data_mem_responder #(
    parameter int          ADDR_WIDTH   = 10,
    parameter int          READ_LATENCY = 2,
    parameter logic [31:0] MMIO_ADDR    = 32'hFFFF_FFFC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [31:0] io_out,
    output logic        io_out_valid,
    output logic [1:0]  dbg_state
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        RESP    = 2'd2
    } state_t;

    state_t                  state_q;
    state_t                  state_d;

    logic [31:0]             mem [0:DEPTH-1];
    logic [31:0]             rdata_q;

    logic [ADDR_WIDTH-1:0]   idx_q;
    logic [3:0]              cnt_q;
    logic                    err_q;
    logic                    write_q;
    logic                    mmio_q;

    logic                    accept;
    logic [ADDR_WIDTH-1:0]   req_idx;
    logic [ADDR_WIDTH-1:0]   rd_idx;
    logic                    req_misaligned;
    logic                    req_out_of_range;
    logic                    req_mmio;
    logic                    req_err;
    logic                    ram_we;

    // Request decode: word index, alignment and range checks.
    assign req_idx          = req_addr[ADDR_WIDTH+1:2];
    assign req_misaligned   = |req_addr[1:0];
    assign req_out_of_range = |req_addr[31:ADDR_WIDTH+2];

`ifdef DATA_MEM_RESPONDER_MMIO_OUT_EN
    assign req_mmio = (req_addr == MMIO_ADDR);
`else
    logic unused_mmio_addr;
    assign req_mmio         = 1'b0;
    assign unused_mmio_addr = ^MMIO_ADDR;
`endif

    // The MMIO word lies above the RAM window but is a legal target when mapped.
    assign req_err   = req_misaligned || (req_out_of_range && !req_mmio);
    assign req_ready = (state_q == IDLE) && !reset;
    assign accept    = req_valid && req_ready;
    assign ram_we    = accept && req_write && !req_err && !req_mmio;

    // Read port address: the live request in IDLE, which covers READ_LATENCY == 1.
    // In the other states it is the latched load index.
    assign rd_idx = (state_q == IDLE) ? req_idx : idx_q;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (req_write || (READ_LATENCY == 1)) begin
                        state_d = RESP;
                    end else begin
                        state_d = RD_WAIT;
                    end
                end
            end
            RD_WAIT: begin
                if (cnt_q <= 4'd1) begin
                    state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Request attributes latched at acceptance, plus the load latency counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            idx_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            write_q <= 1'b0;
            mmio_q  <= 1'b0;
        end else if (accept) begin
            idx_q   <= req_idx;
            cnt_q   <= 4'(READ_LATENCY - 1);
            err_q   <= req_err;
            write_q <= req_write;
            mmio_q  <= req_mmio;
        end else if (state_q == RD_WAIT) begin
            cnt_q   <= cnt_q - 4'd1;
        end
    end

    // RAM: the store commits at its acceptance edge, and the read port is registered.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            mem[req_idx] <= req_wdata;
        end
        rdata_q <= mem[rd_idx];
    end

`ifdef DATA_MEM_RESPONDER_MMIO_OUT_EN
    // MMIO output register, with a one-cycle strobe on each store to it.
    always_ff @(posedge clk) begin
        if (reset) begin
            io_out       <= '0;
            io_out_valid <= 1'b0;
        end else begin
            io_out_valid <= accept && req_write && req_mmio;
            if (accept && req_write && req_mmio) begin
                io_out <= req_wdata;
            end
        end
    end
`else
    assign io_out       = '0;
    assign io_out_valid = 1'b0;
`endif

    // Response outputs: driven only in RESP, data zeroed for stores and errors.
    assign rsp_valid = (state_q == RESP);
    assign rsp_err   = rsp_valid && err_q;
    assign rsp_rdata = (rsp_valid && !err_q && !write_q) ? (mmio_q ? io_out : rdata_q) : 32'h0;
    assign dbg_state = state_q;

endmodule
